iob_f2s_hs_tx: RTL

- Fast-side transmitter of a 4-phase req/ack bundled-data handshake that carries words from the fast clock domain to a slower clock domain.
- Accepts a word with a valid/ready handshake and holds it on data_o for the whole handshake.
- Drives req_o from a register and synchronizes the slow-domain ack_i into clk with a flop chain.
- Sits on the fast side of a fast-to-slow crossing, the opposite direction to the team's slow-to-fast synchronizer.

---
 rtl/iob_f2s_hs_tx.sv | 96 +++++++++
 1 files changed

// File: rtl/iob_f2s_hs_tx.sv
// Fast-side transmitter of a 4-phase req/ack bundled-data handshake into a slower clock domain.
// The accepted word is held on data_o from req_o rise until the synchronized ack falls.
module iob_f2s_hs_tx #(
  parameter int                 DATA_W      = 32,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  RST_VAL     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              done_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("iob_f2s_hs_tx: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    req_nxt;
  logic                    done_nxt;
  logic [DATA_W-1:0]       data_nxt;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    ack_s;

  // ack_i crosses from the slow domain; only the last flop is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s   = sync[SYNC_STAGES-1];
  assign ready_o = (state == IDLE) & ~ack_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_o  <= 1'b0;
      data_o <= RST_VAL;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      req_o  <= req_nxt;
      data_o <= data_nxt;
      done_o <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_o;
    data_nxt  = data_o;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_i && ready_o) begin
          data_nxt  = data_i;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = REL;
        end
      end
      REL: begin
        // The word stays on data_o until the slow side has released ack.
        if (!ack_s) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
